riscv_wb_scoreboard: RTL and testbench

//  In-order writeback scoreboard for the RISC-V pipeline: a bench driver (or on-chip stimulus sequencer)

---
 rtl/riscv_wb_scoreboard_if.sv | 39 +++
 rtl/riscv_wb_scoreboard.sv | 148 ++++++++++++++
 tb/tb_riscv_wb_scoreboard.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_wb_scoreboard_if.sv
// Handshake and status bundle for the writeback scoreboard: expected-entry push,
// retiring writeback events and the run/result status.
interface riscv_wb_scoreboard_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            exp_valid;
  logic            exp_ready;
  logic            exp_last;
  logic [4:0]      exp_rd;
  logic            exp_wen;
  logic [XLEN-1:0] exp_data;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic            wb_wen;
  logic [XLEN-1:0] wb_data;
  logic            busy;
  logic            done;
  logic [15:0]     pass_count;
  logic [15:0]     err_count;
  logic            timeout_err;
  logic            mismatch_pulse;
  logic [4:0]      mismatch_rd;
  logic [XLEN-1:0] mismatch_got;

  modport master (
    output start, exp_valid, exp_last, exp_rd, exp_wen, exp_data,
           wb_valid, wb_rd, wb_wen, wb_data,
    input  exp_ready, busy, done, pass_count, err_count, timeout_err,
           mismatch_pulse, mismatch_rd, mismatch_got
  );

  modport slave (
    input  start, exp_valid, exp_last, exp_rd, exp_wen, exp_data,
           wb_valid, wb_rd, wb_wen, wb_data,
    output exp_ready, busy, done, pass_count, err_count, timeout_err,
           mismatch_pulse, mismatch_rd, mismatch_got
  );
endinterface

// File: rtl/riscv_wb_scoreboard.sv
// In-order writeback scoreboard: queues expected writebacks and compares each retirement against the head.
// Optional SCB_STOP_ON_ERROR_EN: the first error ends the run (RUN/DRAIN -> DONE).
//
// state   | meaning
// S_IDLE  | after reset, waiting for start
// S_RUN   | accepting expected entries and checking retirements
// S_DRAIN | last entry accepted, checking until the FIFO empties
// S_DONE  | run finished (drained, timed out or stopped on error)
module riscv_wb_scoreboard #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  riscv_wb_scoreboard_if.slave sb
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [AW:0]     wptr, rptr, fill;
  logic [AW-1:0]   ridx;
  logic [4:0]      mem_rd   [DEPTH];
  logic            mem_wen  [DEPTH];
  logic [XLEN-1:0] mem_data [DEPTH];
  logic [TW-1:0]   idle_cnt;
  logic [15:0]     pass_q, err_q;
  logic            tout_q, pulse_q;
  logic [4:0]      mis_rd_q;
  logic [XLEN-1:0] mis_got_q;

  logic active, empty, full, push, wb_act, pop, head_match, err;
  logic timeout_hit, clear, stop_err;

  assign active = (state == S_RUN) || (state == S_DRAIN);
  assign fill   = wptr - rptr;
  assign empty  = (wptr == rptr);
  // fill reaches DEPTH exactly when its top bit is set
  assign full   = fill[AW];
  assign ridx   = rptr[AW-1:0];

  assign push   = sb.exp_valid && sb.exp_ready;
  assign wb_act = sb.wb_valid && active;
  assign pop    = wb_act && !empty;

  // x0 writes are architecturally discarded, so their data is not compared
  assign head_match = (mem_rd[ridx] == sb.wb_rd) && (mem_wen[ridx] == sb.wb_wen) &&
                      (!mem_wen[ridx] || (mem_rd[ridx] == 5'd0) || (mem_data[ridx] == sb.wb_data));

  assign err         = wb_act && (empty || !head_match);
  assign timeout_hit = active && !empty && !sb.wb_valid && (idle_cnt == TW'(TIMEOUT - 1));
  assign clear       = sb.start && ((state == S_IDLE) || (state == S_DONE));

`ifdef SCB_STOP_ON_ERROR_EN
  assign stop_err = err;
`else
  assign stop_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: if (sb.start) state_nxt = S_RUN;
      S_RUN: begin
        if (timeout_hit || stop_err)     state_nxt = S_DONE;
        else if (push && sb.exp_last)    state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // finish as soon as the FIFO is empty after this edge
        if (timeout_hit || stop_err || empty || (pop && (fill == (AW+1)'(1))))
          state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wptr[AW-1:0]]   <= sb.exp_rd;
      mem_wen[wptr[AW-1:0]]  <= sb.exp_wen;
      mem_data[wptr[AW-1:0]] <= sb.exp_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  idle_cnt <= '0;
    else if (!active || empty || sb.wb_valid) idle_cnt <= '0;
    else                                      idle_cnt <= idle_cnt + TW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_q    <= '0;
      err_q     <= '0;
      tout_q    <= 1'b0;
      pulse_q   <= 1'b0;
      mis_rd_q  <= '0;
      mis_got_q <= '0;
    end else if (clear) begin
      pass_q    <= '0;
      err_q     <= '0;
      tout_q    <= 1'b0;
      pulse_q   <= 1'b0;
      mis_rd_q  <= '0;
      mis_got_q <= '0;
    end else begin
      if (pop && !err && (pass_q != 16'hFFFF)) pass_q <= pass_q + 16'd1;
      if (err && (err_q != 16'hFFFF))          err_q  <= err_q + 16'd1;
      pulse_q <= err;
      if (err) begin
        mis_rd_q  <= sb.wb_rd;
        mis_got_q <= sb.wb_data;
      end
      if (timeout_hit) tout_q <= 1'b1;
    end
  end

  assign sb.exp_ready      = (state == S_RUN) && !full;
  assign sb.busy           = active;
  assign sb.done           = (state == S_DONE);
  assign sb.pass_count     = pass_q;
  assign sb.err_count      = err_q;
  assign sb.timeout_err    = tout_q;
  assign sb.mismatch_pulse = pulse_q;
  assign sb.mismatch_rd    = mis_rd_q;
  assign sb.mismatch_got   = mis_got_q;
endmodule

// File: tb/tb_riscv_wb_scoreboard.sv
// Directed plus randomized bench for riscv_wb_scoreboard against a queue-based reference model.
module tb_riscv_wb_scoreboard;
  localparam int XLEN    = 32;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 64;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;
`ifdef SCB_STOP_ON_ERROR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  riscv_wb_scoreboard_if #(.XLEN(XLEN)) sb ();

  riscv_wb_scoreboard #(.XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb.slave)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          m_st, m_pass, m_err, m_idle;
  logic        m_tout, m_pulse;
  logic [4:0]  m_rd;
  logic [31:0] m_got;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; q.delete(); m_pass = 0; m_err = 0; m_idle = 0;
    m_tout = 1'b0; m_pulse = 1'b0; m_rd = '0; m_got = '0;
  endtask

  task automatic chk_outputs();
    chk("exp_ready", 64'(sb.exp_ready), 64'((m_st == M_RUN) && (q.size() < DEPTH)));
    chk("busy", 64'(sb.busy), 64'((m_st == M_RUN) || (m_st == M_DRAIN)));
    chk("done", 64'(sb.done), 64'(m_st == M_DONE));
    chk("pass_count", 64'(sb.pass_count), 64'(m_pass));
    chk("err_count", 64'(sb.err_count), 64'(m_err));
    chk("timeout_err", 64'(sb.timeout_err), 64'(m_tout));
    chk("mismatch_pulse", 64'(sb.mismatch_pulse), 64'(m_pulse));
    chk("mismatch_rd", 64'(sb.mismatch_rd), 64'(m_rd));
    chk("mismatch_got", 64'(sb.mismatch_got), 64'(m_got));
  endtask

  task automatic idle_inputs();
    sb.start = 0; sb.exp_valid = 0; sb.exp_last = 0; sb.exp_rd = 0; sb.exp_wen = 0;
    sb.exp_data = 0; sb.wb_valid = 0; sb.wb_rd = 0; sb.wb_wen = 0; sb.wb_data = 0;
  endtask

  // One clock: update the model from the current inputs, clock, then compare.
  task automatic tick();
    bit   rdy, push, act, err, tout, match, run;
    ent_t h, e;
    run  = (m_st == M_RUN) || (m_st == M_DRAIN);
    rdy  = (m_st == M_RUN) && (q.size() < DEPTH);
    push = sb.exp_valid && rdy;
    act  = sb.wb_valid && run;
    err  = 0;
    tout = 0;
    if (run && q.size() != 0 && !sb.wb_valid) begin
      m_idle++;
      tout = (m_idle == TIMEOUT);
    end else begin
      m_idle = 0;
    end
    if (act) begin
      if (q.size() == 0) err = 1;
      else begin
        h = q.pop_front();
        match = (h.rd == sb.wb_rd) && (h.wen == sb.wb_wen) &&
                (!h.wen || h.rd == 0 || h.data == sb.wb_data);
        if (match) begin
          if (m_pass < 65535) m_pass++;
        end else err = 1;
      end
    end
    if (push) begin
      e.rd = sb.exp_rd; e.wen = sb.exp_wen; e.data = sb.exp_data;
      q.push_back(e);
    end
    m_pulse = err;
    if (err) begin
      if (m_err < 65535) m_err++;
      m_rd = sb.wb_rd; m_got = sb.wb_data;
    end
    if (tout) begin m_tout = 1'b1; m_idle = 0; end
    case (m_st)
      M_IDLE, M_DONE:
        if (sb.start) begin
          m_st = M_RUN; q.delete(); m_pass = 0; m_err = 0; m_tout = 0;
          m_rd = 0; m_got = 0; m_pulse = 0; m_idle = 0;
        end
      M_RUN:
        if (tout || (STOP && err)) m_st = M_DONE;
        else if (push && sb.exp_last) m_st = M_DRAIN;
      M_DRAIN:
        if (tout || (STOP && err) || q.size() == 0) m_st = M_DONE;
      default: m_st = M_IDLE;
    endcase
    @(posedge clk);
    #1;
    chk_outputs();
  endtask

  task automatic start_run();
    sb.start = 1; tick(); sb.start = 0;
  endtask

  task automatic push(input logic [4:0] rd, input logic wen, input logic [31:0] d, input logic last);
    sb.exp_valid = 1; sb.exp_rd = rd; sb.exp_wen = wen; sb.exp_data = d; sb.exp_last = last;
    tick();
    sb.exp_valid = 0; sb.exp_last = 0;
  endtask

  task automatic wb(input logic [4:0] rd, input logic wen, input logic [31:0] d);
    sb.wb_valid = 1; sb.wb_rd = rd; sb.wb_wen = wen; sb.wb_data = d;
    tick();
    sb.wb_valid = 0;
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic do_reset();
    idle_inputs();
    rst = 1;
    #2;
    model_reset();
    chk_outputs();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ent_t h;
    idle_inputs();
    rst = 1;
    #1;
    model_reset();
    chk_outputs();
    chk("reset_exp_ready", 64'(sb.exp_ready), 64'(0));
    @(posedge clk);
    #1;
    rst = 0;
    tick();

    // two matching retirements, done right after the second
    start_run();
    push(5'd1, 1'b1, 32'h8, 1'b0);
    push(5'd1, 1'b1, 32'h11, 1'b1);
    wb(5'd1, 1'b1, 32'h8);
    wb(5'd1, 1'b1, 32'h11);
    chk("t1_pass", 64'(sb.pass_count), 64'(2));
    chk("t1_err", 64'(sb.err_count), 64'(0));
    chk("t1_done", 64'(sb.done), 64'(1));

    // data mismatch
    start_run();
    push(5'd1, 1'b1, 32'h8, 1'b1);
    wb(5'd1, 1'b1, 32'h9);
    chk("t2_err", 64'(sb.err_count), 64'(1));
    chk("t2_pulse", 64'(sb.mismatch_pulse), 64'(1));
    chk("t2_rd", 64'(sb.mismatch_rd), 64'(1));
    chk("t2_got", 64'(sb.mismatch_got), 64'(9));
    tick();
    chk("t2_pulse_clr", 64'(sb.mismatch_pulse), 64'(0));

    // x0 data ignored, wen=0 entry matches
    start_run();
    push(5'd0, 1'b1, 32'h5, 1'b0);
    push(5'd3, 1'b0, 32'h1234, 1'b1);
    wb(5'd0, 1'b1, 32'h7);
    wb(5'd3, 1'b0, 32'h99);
    chk("t3_pass", 64'(sb.pass_count), 64'(2));
    chk("t3_err", 64'(sb.err_count), 64'(0));

    // full FIFO backpressure, start ignored mid-run, then timeout
    start_run();
    for (int i = 0; i < DEPTH; i++) push(5'(i + 1), 1'b1, 32'(i), 1'b0);
    chk("t4_full_ready", 64'(sb.exp_ready), 64'(0));
    sb.exp_valid = 1; sb.exp_rd = 5'd20; sb.exp_wen = 1; sb.exp_data = 32'hAA;
    sb.start = 1;
    tick();
    sb.start = 0;
    tick();
    sb.wb_valid = 1; sb.wb_rd = 5'd1; sb.wb_wen = 1; sb.wb_data = 32'h0;
    tick();
    sb.wb_valid = 0;
    chk("t4_ready_after_pop", 64'(sb.exp_ready), 64'(1));
    tick();
    sb.exp_valid = 0;
    for (int i = 0; i < 80 && m_st != M_DONE; i++) tick();
    chk("t4_timeout", 64'(sb.timeout_err), 64'(1));
    chk("t4_done", 64'(sb.done), 64'(1));
    wb(5'd2, 1'b1, 32'h1);
    chk("t4_pass_held", 64'(sb.pass_count), 64'(1));
    chk("t4_err_held", 64'(sb.err_count), 64'(0));

    // unexpected retirement with an empty FIFO
    start_run();
    wb(5'd5, 1'b1, 32'h3);
    chk("t5_err", 64'(sb.err_count), 64'(1));
    chk("t5_done", 64'(sb.done), 64'(STOP));
    start_run();
    push(5'd2, 1'b1, 32'h4, 1'b0);
    do_reset();
    tick();

    // randomized runs
    for (int run = 0; run < 25; run++) begin
      start_run();
      for (int c = 0; c < 400 && m_st != M_DONE; c++) begin
        sb.exp_valid = 1'($urandom_range(0, 1));
        sb.exp_last  = ($urandom_range(0, 19) == 0);
        sb.exp_rd    = 5'($urandom_range(0, 4));
        sb.exp_wen   = 1'($urandom_range(0, 1));
        sb.exp_data  = $urandom;
        sb.wb_valid  = ($urandom_range(0, 9) < 4);
        if (q.size() > 0 && $urandom_range(0, 9) < 8) begin
          h = q[0];
          sb.wb_rd = h.rd; sb.wb_wen = h.wen; sb.wb_data = h.data;
          if ($urandom_range(0, 9) == 0) sb.wb_data = h.data ^ 32'h1;
          if ($urandom_range(0, 19) == 0) sb.wb_rd = h.rd ^ 5'h1;
        end else begin
          sb.wb_rd = 5'($urandom_range(0, 4)); sb.wb_wen = 1'($urandom_range(0, 1));
          sb.wb_data = $urandom;
        end
        tick();
      end
      idle_inputs();
      if (m_st != M_DONE) do_reset();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
